// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: WIDTH-bit adder/subtractor whose carry chain is cut into
// STAGES equal slices, one slice per register stage, behind a stallable
// valid/ready pipe. WIDTH must be a multiple of STAGES.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             c0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_en;
    logic              w_ovf_nxt;
    logic              w_zero_nxt;
    logic              r_ovf;
    logic              r_zero;

    // Stage k may advance if the consumer takes the head or any stage at or
    // after k is empty, so bubbles collapse while the output is stalled.
    always_comb begin
        w_en = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_en[k] = out_ready | (|(~r_v >> k));
        end
    end

    // Valid bits shift forward wherever the stage is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            if (w_en[0]) r_v[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                if (w_en[k]) r_v[k] <= r_v[k-1];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        // Operand bits still to be summed at this stage: [WIDTH-1 : k*SW].
        localparam int HW = WIDTH - k * SW;

        logic [HW-1:0]         w_a;
        logic [HW-1:0]         w_b;
        logic                  w_cin;
        logic [SW:0]           w_sum;
        logic [(k+1)*SW-1:0]   w_s_nxt;
        logic [(k+1)*SW-1:0]   r_s;
        logic                  r_c;

        if (k == 0) begin : g_src
            // Subtract is A + ~B + ~borrow_in.
            assign w_a   = in1;
            assign w_b   = sub ? ~in2 : in2;
            assign w_cin = c0 ^ sub;
        end else begin : g_src
            assign w_a   = gen_stage[k-1].g_keep.r_a;
            assign w_b   = gen_stage[k-1].g_keep.r_b;
            assign w_cin = gen_stage[k-1].r_c;
        end

        assign w_sum = {1'b0, w_a[SW-1:0]} + {1'b0, w_b[SW-1:0]} + {{SW{1'b0}}, w_cin};

        if (k == 0) begin : g_acc
            assign w_s_nxt = w_sum[SW-1:0];
        end else begin : g_acc
            assign w_s_nxt = {w_sum[SW-1:0], gen_stage[k-1].r_s};
        end

        // Partial result and slice carry move on when the stage is enabled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s <= '0;
                r_c <= 1'b0;
            end else if (w_en[k]) begin
                r_s <= w_s_nxt;
                r_c <= w_sum[SW];
            end
        end

        if (k < STAGES - 1) begin : g_keep
            logic [HW-SW-1:0] r_a;
            logic [HW-SW-1:0] r_b;

            // Only the not-yet-added upper operand slices travel onward.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en[k]) begin
                    r_a <= w_a[HW-1:SW];
                    r_b <= w_b[HW-1:SW];
                end
            end
        end else begin : g_last
            assign w_ovf_nxt  = (w_a[HW-1] == w_b[HW-1]) && (w_sum[SW-1] != w_a[HW-1]);
            assign w_zero_nxt = ~|w_s_nxt;
        end
    end

    // Flags are registered alongside the final slice so they read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en[STAGES-1]) begin
            r_ovf  <= w_ovf_nxt;
            r_zero <= w_zero_nxt;
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = r_v[STAGES-1];
    assign sout      = gen_stage[STAGES-1].r_s;
    assign cout      = gen_stage[STAGES-1].r_c;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: directed corner beats, random streaming with
// random back-pressure, full-pipe stall, mid-cycle reset, and S=1 / S=32.
module tb_pipelined_add_sub;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    logic        clk, rst;
    logic        in_valid, in_ready, sub, c0, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] in1, in2, sout;

    logic        d_in_valid, d_sub, d_c0, d_out_ready;
    logic [31:0] d_in1, d_in2;
    logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf, d1_zero;
    logic [31:0] d1_sout;
    logic        d32_in_ready, d32_out_valid, d32_cout, d32_ovf, d32_zero;
    logic [31:0] d32_sout;

    int checks   = 0;
    int failures = 0;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sub(sub), .c0(c0), .in1(in1), .in2(in2),
        .out_valid(out_valid), .out_ready(out_ready), .sout(sout),
        .cout(cout), .overflow(ovf), .zero(zero));

    pipelined_add_sub #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d1_in_ready),
        .sub(d_sub), .c0(d_c0), .in1(d_in1), .in2(d_in2),
        .out_valid(d1_out_valid), .out_ready(d_out_ready), .sout(d1_sout),
        .cout(d1_cout), .overflow(d1_ovf), .zero(d1_zero));

    pipelined_add_sub #(.WIDTH(32), .STAGES(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d32_in_ready),
        .sub(d_sub), .c0(d_c0), .in1(d_in1), .in2(d_in2),
        .out_valid(d32_out_valid), .out_ready(d_out_ready), .sout(d32_sout),
        .cout(d32_cout), .overflow(d32_ovf), .zero(d32_zero));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then reduce to the flag definitions.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic ci);
        res_t   m;
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint lc = ci;
        longint r, sr;
        if (s) begin
            r   = ua - ub - lc;
            sr  = sa - sb - lc;
            m.c = (r >= 0);
        end else begin
            r   = ua + ub + lc;
            sr  = sa + sb + lc;
            m.c = (r >= 64'sd4294967296);
        end
        m.s = r[31:0];
        m.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        m.z = (m.s == 32'd0);
        return m;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, sout, cout, ovf, zero} !== 36'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b z=%b want all 0",
                     out_valid, sout, cout, ovf, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || d1_in_ready !== 1'b1 || d32_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b/%b/%b want 1/1/1",
                     in_ready, d1_in_ready, d32_in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [7] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0000_FFFF,
                                32'h7FFF_FFFF, 32'd0, 32'd3};
        logic [31:0] tb [7] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'd1, 32'd0, 32'd3};
        logic        ts [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        tc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        res_t        te [7] = '{{32'h0000_0000, 1'b1, 1'b0, 1'b1},
                                {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
                                {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
                                {32'h0001_0001, 1'b0, 1'b0, 1'b0},
                                {32'h8000_0000, 1'b0, 1'b1, 1'b0},
                                {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0},
                                {32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        for (int i = 0; i < 7; i++) begin
            int lat;
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in1 = ta[i]; in2 = tb[i]; sub = ts[i]; c0 = tc[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != 4) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if ({sout, cout, ovf, zero} !== te[i]) begin
                failures++;
                $display("FAIL dir%0d_result: got s=%h c=%b o=%b z=%b want s=%h c=%b o=%b z=%b",
                         i, sout, cout, ovf, zero, te[i].s, te[i].c, te[i].v, te[i].z);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_single_pulse: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_stream();
        res_t q[$];
        res_t prev = '0;
        logic prev_stall = 1'b0;
        int   acc = 0;
        int   cyc = 0;
        while ((acc < 100 || q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {sout, cout, ovf, zero} !== prev) begin
                    failures++;
                    $display("FAIL stream_hold: got v=%b %h want v=1 %h",
                             out_valid, {sout, cout, ovf, zero}, prev);
                end
            end
            in_valid  = (acc < 100) && ($urandom_range(0, 3) != 0);
            out_ready = $urandom_range(0, 1);
            in1 = rand_op(); in2 = rand_op();
            sub = $urandom_range(0, 1); c0 = $urandom_range(0, 1);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra: got beat %h want none", {sout, cout, ovf, zero});
                end else begin
                    res_t e = q.pop_front();
                    if ({sout, cout, ovf, zero} !== e) begin
                        failures++;
                        $display("FAIL stream_data: got %h want %h", {sout, cout, ovf, zero}, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev       = {sout, cout, ovf, zero};
            if (in_valid && in_ready) begin
                q.push_back(model(in1, in2, sub, c0));
                acc++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (cyc >= 3000) begin
            failures++;
            $display("FAIL stream_timeout: got acc=%0d pending=%0d want 100/0", acc, q.size());
        end
    endtask

    task automatic test_stall();
        res_t q[$];
        int   acc = 0;
        int   drained = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            in1 = 32'd100 + acc; in2 = acc; sub = 1'b0; c0 = 1'b0;
            #1;
            if (in_ready) begin
                q.push_back(model(in1, in2, sub, c0));
                acc++;
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (acc != 4) begin
            failures++;
            $display("FAIL stall_accepted: got %0d want 4", acc);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready: got %b want 1", in_ready);
        end
        for (int n = 0; n < 12; n++) begin
            if (out_valid) begin
                checks++;
                drained++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stall_extra: got %h want none", sout);
                end else begin
                    res_t e = q.pop_front();
                    if ({sout, cout, ovf, zero} !== e) begin
                        failures++;
                        $display("FAIL stall_order: got %h want %h", {sout, cout, ovf, zero}, e);
                    end
                end
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (drained != 4) begin
            failures++;
            $display("FAIL stall_drained: got %0d want 4", drained);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   stale = 0;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFF0 + i; sub = 1'b0; c0 = 1'b0;
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: got %b want 1", out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, sout, cout, ovf, zero} !== 36'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got v=%b s=%h c=%b o=%b z=%b want all 0",
                     out_valid, sout, cout, ovf, zero);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release: got rdy=%b v=%b want 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in1 = 32'h1234_5678; in2 = 32'h0000_0001; sub = 1'b0; c0 = 1'b0;
        e = model(in1, in2, sub, c0);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || {sout, cout, ovf, zero} !== e) begin
            failures++;
            $display("FAIL midreset_next_beat: got lat=%0d %h want lat=4 %h",
                     lat, {sout, cout, ovf, zero}, e);
        end
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL midreset_stale: got %0d extra beats want 0", stale);
        end
    endtask

    task automatic test_degenerate();
        int   lat1 = 0, lat32 = 0, cnt1 = 0, cnt32 = 0;
        res_t r1 = '0, r32 = '0;
        res_t e = {32'h0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        d_in_valid = 1'b1;
        d_in1 = 32'hFFFF_FFFF; d_in2 = 32'h1; d_sub = 1'b0; d_c0 = 1'b0;
        #1;
        checks++;
        if (d1_in_ready !== 1'b1 || d32_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL deg_in_ready: got %b/%b want 1/1", d1_in_ready, d32_in_ready);
        end
        @(negedge clk);
        d_in_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (d1_out_valid) begin
                cnt1++;
                if (lat1 == 0) begin lat1 = n; r1 = {d1_sout, d1_cout, d1_ovf, d1_zero}; end
            end
            if (d32_out_valid) begin
                cnt32++;
                if (lat32 == 0) begin lat32 = n; r32 = {d32_sout, d32_cout, d32_ovf, d32_zero}; end
            end
            @(negedge clk);
        end
        checks++;
        if (lat1 != 1 || cnt1 != 1) begin
            failures++;
            $display("FAIL s1_latency: got lat=%0d pulses=%0d want 1/1", lat1, cnt1);
        end
        checks++;
        if (r1 !== e) begin
            failures++;
            $display("FAIL s1_result: got %h want %h", r1, e);
        end
        checks++;
        if (lat32 != 32 || cnt32 != 1) begin
            failures++;
            $display("FAIL s32_latency: got lat=%0d pulses=%0d want 32/1", lat32, cnt32);
        end
        checks++;
        if (r32 !== e) begin
            failures++;
            $display("FAIL s32_result: got %h want %h", r32, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; c0 = 1'b0; in1 = '0; in2 = '0;
        d_in_valid = 1'b0; d_out_ready = 1'b1; d_sub = 1'b0; d_c0 = 1'b0;
        d_in1 = '0; d_in2 = '0;
        @(posedge clk);
        test_reset();
        test_directed();
        test_stream();
        test_stall();
        test_reset_mid();
        test_degenerate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
